llki_pp_responder: RTL and testbench

LLKI_PP_RESPONDER -- requirements
Module: llki_pp_responder

---
 rtl/llki_pp_responder.sv | 182 ++++++++++++++++++
 tb/tb_llki_pp_responder.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llki_pp_responder.sv
// LLKI protocol-processor responder.
// Accepts LLKI-KL messages through a two-register interface (control/status
// and send/receive), forwards key words to the TSS over a valid/ready
// handshake, drives key-clear requests, and posts a one-word response that
// software collects by reading the send/receive register.
module llki_pp_responder #(
  parameter logic [31:0] CTRLSTS_ADDR  = 32'h7000_8000,
  parameter logic [31:0] SENDRECV_ADDR = 32'h7000_8008
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] reg_addr,
  input  logic        reg_wr_en,
  input  logic [63:0] reg_wr_data,
  input  logic        reg_rd_en,
  output logic [63:0] reg_rd_data,
  output logic [63:0] llkid_key_data,
  output logic        llkid_key_valid,
  input  logic        llkid_key_ready,
  input  logic        llkid_key_complete,
  output logic        llkid_clear_key,
  input  logic        llkid_clear_key_ack
);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    MESSAGE_CHECK  = 3'd1,
    LOAD_KEY_WORDS = 3'd2,
    CLEAR_KEY      = 3'd3,
    RESPONSE       = 3'd4
  } state_t;

  localparam logic [7:0] ID_LOAD_KEY    = 8'h07;
  localparam logic [7:0] ID_CLEAR_KEY   = 8'h08;
  localparam logic [7:0] ID_KEY_STATUS  = 8'h09;
  localparam logic [7:0] ID_ERROR       = 8'h06;
  localparam logic [7:0] ID_LOAD_ACK    = 8'h0A;
  localparam logic [7:0] ID_CLEAR_ACK   = 8'h0B;
  localparam logic [7:0] ID_STATUS_RESP = 8'h0C;

  state_t      state_r;
  logic [7:0]  msg_id_r;
  logic [7:0]  msg_len_r;
  logic [7:0]  remaining_r;
  logic [7:0]  resp_id_r;
  logic [7:0]  resp_status_r;
  logic [63:0] resp_word_r;
  logic        resp_waiting_r;
  logic        ready_for_key_s;
  logic        sr_wr_s;
  logic        sr_rd_s;

  assign sr_wr_s = reg_wr_en && (reg_addr == SENDRECV_ADDR);
  assign sr_rd_s = reg_rd_en && (reg_addr == SENDRECV_ADDR);

  // Host may write the next word when idle or when no key word is outstanding
  always_comb begin
    ready_for_key_s = 1'b0;
    if (state_r == IDLE) begin
      ready_for_key_s = 1'b1;
    end else if (state_r == LOAD_KEY_WORDS) begin
      ready_for_key_s = !llkid_key_valid;
    end else begin
      ready_for_key_s = 1'b0;
    end
  end

  // Message FSM: header decode, key forwarding, key clear and response posting
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      msg_id_r        <= 8'h00;
      msg_len_r       <= 8'h00;
      remaining_r     <= 8'h00;
      resp_id_r       <= 8'h00;
      resp_status_r   <= 8'h00;
      resp_word_r     <= 64'h0;
      resp_waiting_r  <= 1'b0;
      llkid_key_data  <= 64'h0;
      llkid_key_valid <= 1'b0;
      llkid_clear_key <= 1'b0;
    end else begin
      // Collecting the response consumes it; a new response below takes priority
      if (sr_rd_s) begin
        resp_waiting_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (sr_wr_s) begin
            msg_id_r       <= reg_wr_data[7:0];
            msg_len_r      <= reg_wr_data[23:16];
            resp_waiting_r <= 1'b0;
            state_r        <= MESSAGE_CHECK;
          end
        end
        MESSAGE_CHECK: begin
          // Illegal length on a known ID is reported as 0x27 by default
          resp_id_r     <= ID_ERROR;
          resp_status_r <= 8'h27;
          state_r       <= RESPONSE;
          case (msg_id_r)
            ID_LOAD_KEY: begin
              if (msg_len_r >= 8'd2) begin
                remaining_r <= msg_len_r - 8'd1;
                state_r     <= LOAD_KEY_WORDS;
              end
            end
            ID_CLEAR_KEY: begin
              if (msg_len_r == 8'd1) begin
                llkid_clear_key <= 1'b1;
                state_r         <= CLEAR_KEY;
              end
            end
            ID_KEY_STATUS: begin
              if (msg_len_r == 8'd1) begin
                resp_id_r     <= ID_STATUS_RESP;
                resp_status_r <= llkid_key_complete ? 8'h01 : 8'h02;
              end
            end
            default: begin
              resp_status_r <= 8'h26;
            end
          endcase
        end
        LOAD_KEY_WORDS: begin
          if (llkid_key_valid) begin
            if (sr_wr_s) begin
              // Host wrote ahead of the TSS: drop the word, report loss of sync
              llkid_key_valid <= 1'b0;
              resp_id_r       <= ID_ERROR;
              resp_status_r   <= 8'h30;
              state_r         <= RESPONSE;
            end else if (llkid_key_ready) begin
              llkid_key_valid <= 1'b0;
              remaining_r     <= remaining_r - 8'd1;
              if (remaining_r == 8'd1) begin
                resp_id_r     <= ID_LOAD_ACK;
                resp_status_r <= 8'h00;
                state_r       <= RESPONSE;
              end
            end
          end else if (sr_wr_s) begin
            llkid_key_data  <= reg_wr_data;
            llkid_key_valid <= 1'b1;
          end
        end
        CLEAR_KEY: begin
          if (llkid_clear_key_ack) begin
            llkid_clear_key <= 1'b0;
            resp_id_r       <= ID_CLEAR_ACK;
            resp_status_r   <= 8'h00;
            state_r         <= RESPONSE;
          end
        end
        RESPONSE: begin
          resp_word_r    <= {40'h0, 8'h01, resp_status_r, resp_id_r};
          resp_waiting_r <= 1'b1;
          state_r        <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Registered read port; holds its value between read strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_rd_data <= 64'h0;
    end else if (reg_rd_en) begin
      if (reg_addr == CTRLSTS_ADDR) begin
        reg_rd_data <= {62'h0, ready_for_key_s, resp_waiting_r};
      end else if (reg_addr == SENDRECV_ADDR) begin
        reg_rd_data <= resp_waiting_r ? resp_word_r : 64'h0;
      end else begin
        reg_rd_data <= 64'h0;
      end
    end
  end

endmodule

// File: tb/tb_llki_pp_responder.sv
// Scoreboard bench for llki_pp_responder: stimulus tasks push expected read
// data and expected key words into queues; a monitor on the falling edge pops
// and compares whenever the DUT returns read data or completes a key handshake.
module tb_llki_pp_responder;

  localparam logic [31:0] CS    = 32'h7000_8000;
  localparam logic [31:0] SR    = 32'h7000_8008;
  localparam logic [31:0] OTHER = 32'h7000_8010;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] reg_addr;
  logic        reg_wr_en;
  logic [63:0] reg_wr_data;
  logic        reg_rd_en;
  logic [63:0] reg_rd_data;
  logic [63:0] llkid_key_data;
  logic        llkid_key_valid;
  logic        llkid_key_ready;
  logic        llkid_key_complete;
  logic        llkid_clear_key;
  logic        llkid_clear_key_ack;

  llki_pp_responder dut (
    .clk                 (clk),
    .rst                 (rst),
    .reg_addr            (reg_addr),
    .reg_wr_en           (reg_wr_en),
    .reg_wr_data         (reg_wr_data),
    .reg_rd_en           (reg_rd_en),
    .reg_rd_data         (reg_rd_data),
    .llkid_key_data      (llkid_key_data),
    .llkid_key_valid     (llkid_key_valid),
    .llkid_key_ready     (llkid_key_ready),
    .llkid_key_complete  (llkid_key_complete),
    .llkid_clear_key     (llkid_clear_key),
    .llkid_clear_key_ack (llkid_clear_key_ack)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] rd_q[$];
  logic [63:0] key_q[$];
  logic        rd_seen = 1'b0;
  logic        hs_prev = 1'b0;

  // Reference state of the software-visible response mailbox
  logic        m_waiting;
  logic [63:0] m_word;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Response code {status, id} derived from the message rules
  function automatic logic [15:0] expect_code(input logic [7:0] id, input logic [7:0] len,
                                              input logic comp);
    case (id)
      8'h07:   return (len >= 8'd2) ? 16'h000A : 16'h2706;
      8'h08:   return (len == 8'd1) ? 16'h000B : 16'h2706;
      8'h09:   return (len == 8'd1) ? (comp ? 16'h010C : 16'h020C) : 16'h2706;
      default: return 16'h2606;
    endcase
  endfunction

  // Remember which edges carried a read strobe
  always @(posedge clk) rd_seen <= reg_rd_en;

  // Monitor: compare read data and key handshakes against the queues
  always @(negedge clk) begin
    if (rd_seen) begin
      if (rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read actual=%h expected=none", reg_rd_data);
      end else begin
        chk("read_data", reg_rd_data, rd_q.pop_front());
      end
    end
    if (hs_prev) chk("valid_single_cycle", {63'h0, llkid_key_valid}, 64'h0);
    hs_prev <= llkid_key_valid && llkid_key_ready;
    if (llkid_key_valid && llkid_key_ready) begin
      if (key_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_key actual=%h expected=none", llkid_key_data);
      end else begin
        chk("key_data", llkid_key_data, key_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [63:0] d);
    reg_addr    = a;
    reg_wr_data = d;
    reg_wr_en   = 1'b1;
    tick(1);
    reg_wr_en   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [63:0] e);
    reg_addr  = a;
    reg_rd_en = 1'b1;
    rd_q.push_back(e);
    tick(1);
    reg_rd_en = 1'b0;
  endtask

  // Header with random don't-care bits in the status and upper fields
  task automatic send_header(input logic [7:0] id, input logic [7:0] len);
    logic [63:0] h;
    h = {$urandom, $urandom};
    h[23:16] = len;
    h[7:0]   = id;
    wr(SR, h);
    m_waiting = 1'b0;
  endtask

  task automatic post(input logic [15:0] code);
    m_word    = {40'h0, 8'h01, code};
    m_waiting = 1'b1;
  endtask

  task automatic collect();
    tick(3);
    rd(CS, {62'h0, 1'b1, m_waiting});
    rd(SR, m_waiting ? m_word : 64'h0);
    m_waiting = 1'b0;
    rd(CS, 64'h2);
  endtask

  task automatic key_msg(input logic [7:0] len, input bit fast);
    logic [63:0] w;
    send_header(8'h07, len);
    tick(1);
    for (int i = 1; i < len; i++) begin
      w = {$urandom, $urandom};
      if (fast) begin
        llkid_key_ready = 1'b1;
        key_q.push_back(w);
        wr(SR, w);
        tick(2);
      end else begin
        llkid_key_ready = 1'b0;
        wr(SR, w);
        rd(CS, 64'h0);
        tick($urandom_range(0, 3));
        key_q.push_back(w);
        llkid_key_ready = 1'b1;
        tick(1);
        llkid_key_ready = 1'b0;
        tick(1);
      end
    end
    llkid_key_ready = 1'b0;
    post(expect_code(8'h07, len, 1'b0));
    collect();
  endtask

  task automatic clear_msg(input int d);
    send_header(8'h08, 8'd1);
    tick(1);
    for (int k = 0; k < d; k++) begin
      chk("clear_held", {63'h0, llkid_clear_key}, 64'h1);
      if (k == 0) wr(SR, {$urandom, $urandom});
      else tick(1);
    end
    llkid_clear_key_ack = 1'b1;
    chk("clear_at_ack", {63'h0, llkid_clear_key}, 64'h1);
    tick(1);
    llkid_clear_key_ack = 1'b0;
    chk("clear_dropped", {63'h0, llkid_clear_key}, 64'h0);
    post(expect_code(8'h08, 8'd1, 1'b0));
    collect();
  endtask

  task automatic status_msg(input logic comp);
    llkid_key_complete = comp;
    send_header(8'h09, 8'd1);
    tick(1);
    llkid_key_complete = 1'($urandom);
    post(expect_code(8'h09, 8'd1, comp));
    collect();
  endtask

  task automatic error_msg(input logic [7:0] id, input logic [7:0] len);
    send_header(id, len);
    post(expect_code(id, len, 1'b0));
    collect();
  endtask

  task automatic loss_sync_msg();
    logic [7:0] len;
    len = 8'($urandom_range(3, 6));
    llkid_key_ready = 1'b0;
    send_header(8'h07, len);
    tick(1);
    wr(SR, {$urandom, $urandom});
    rd(CS, 64'h0);
    wr(SR, {$urandom, $urandom});
    chk("sync_valid_dropped", {63'h0, llkid_key_valid}, 64'h0);
    post(16'h3006);
    collect();
  endtask

  task automatic random_error();
    logic [7:0] id;
    logic [7:0] len;
    case ($urandom_range(0, 3))
      0: begin
        id = 8'($urandom);
        while (id >= 8'h07 && id <= 8'h09) id = 8'($urandom);
        len = 8'($urandom);
      end
      1: begin
        id = 8'h07;
        len = 8'($urandom_range(0, 1));
      end
      2: begin
        id = 8'h08;
        len = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(2, 255));
      end
      default: begin
        id = 8'h09;
        len = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(2, 255));
      end
    endcase
    error_msg(id, len);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    reg_addr = 32'h0;
    reg_wr_en = 1'b0;
    reg_wr_data = 64'h0;
    reg_rd_en = 1'b0;
    llkid_key_ready = 1'b0;
    llkid_key_complete = 1'b0;
    llkid_clear_key_ack = 1'b0;
    m_waiting = 1'b0;
    m_word = 64'h0;
    tick(3);
    rst = 1'b0;

    // Reset state
    chk("rst_rd_data", reg_rd_data, 64'h0);
    chk("rst_key_data", llkid_key_data, 64'h0);
    chk("rst_key_valid", {63'h0, llkid_key_valid}, 64'h0);
    chk("rst_clear_key", {63'h0, llkid_clear_key}, 64'h0);
    rd(CS, 64'h2);
    rd(SR, 64'h0);
    rd(OTHER, 64'h0);
    wr(CS, {$urandom, $urandom});
    wr(OTHER, 64'h0001_0009);
    tick(3);
    rd(CS, 64'h2);
    chk("rd_data_holds", reg_rd_data, 64'h2);

    // Directed scenarios
    key_msg(8'd3, 1'b1);
    clear_msg(5);
    status_msg(1'b1);
    status_msg(1'b0);
    error_msg(8'h55, 8'd1);
    error_msg(8'h08, 8'd2);
    loss_sync_msg();

    // Same-cycle read of the old response and a new header write
    llkid_key_complete = 1'b1;
    send_header(8'h09, 8'd1);
    post(16'h010C);
    tick(3);
    reg_addr = SR;
    reg_rd_en = 1'b1;
    reg_wr_en = 1'b1;
    reg_wr_data = 64'h0001_0009;
    rd_q.push_back(m_word);
    llkid_key_complete = 1'b0;
    tick(1);
    reg_rd_en = 1'b0;
    reg_wr_en = 1'b0;
    m_waiting = 1'b0;
    post(16'h020C);
    collect();

    // Reset with a key word pending
    send_header(8'h07, 8'd3);
    tick(1);
    wr(SR, {$urandom, $urandom});
    chk("pending_valid", {63'h0, llkid_key_valid}, 64'h1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst_drops_valid", {63'h0, llkid_key_valid}, 64'h0);
    m_waiting = 1'b0;
    rd(CS, 64'h2);
    status_msg(1'b1);

    // Reset during a key clear: no response afterwards
    send_header(8'h08, 8'd1);
    tick(1);
    chk("clear_before_rst", {63'h0, llkid_clear_key}, 64'h1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst_drops_clear", {63'h0, llkid_clear_key}, 64'h0);
    tick(2);
    rd(CS, 64'h2);
    rd(SR, 64'h0);

    // Randomized message mix
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 4))
        0: key_msg(8'($urandom_range(2, 5)), 1'($urandom));
        1: clear_msg($urandom_range(1, 4));
        2: status_msg(1'($urandom));
        3: random_error();
        default: loss_sync_msg();
      endcase
    end

    tick(3);
    chk("read_queue_drained", 64'(rd_q.size()), 64'h0);
    chk("key_queue_drained", 64'(key_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
